// File: rtl/energy_tx_pkg.sv
// Shared definitions for the energy telemetry transmitter.
//   SYNC_BYTE   : first byte of every frame
//   FRAME_BYTES : bytes per frame (sync, seq, sample, chk)
//   tx_state_e  : serializer FSM states
//   frame_t     : payload latched at frame start
package energy_tx_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
  localparam int unsigned FRAME_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] seq;
    logic [BYTE_W-1:0] sample;
  } frame_t;

  // Byte of the frame at position idx; chk = sync ^ seq ^ sample.
  function automatic logic [BYTE_W-1:0] frame_byte(input frame_t f, input logic [1:0] idx);
    logic [BYTE_W-1:0] b;
    b = SYNC_BYTE;
    case (idx)
      2'd0:    b = SYNC_BYTE;
      2'd1:    b = f.seq;
      2'd2:    b = f.sample;
      default: b = SYNC_BYTE ^ f.seq ^ f.sample;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/telemetry_fifo.sv
// Sample buffer for the telemetry transmitter.
//   clk, rst     : clock, synchronous active-high reset (empties the buffer)
//   i_push       : write i_wr_data (ignored when full)
//   i_pop        : drop the head entry (ignored when empty)
//   o_rd_data    : head entry, valid while o_empty is 0
//   o_full       : registered full flag
//   o_empty      : registered empty flag
//   o_full_nxt_c : full flag as it will be after this edge (combinational)
module telemetry_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_full_nxt_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;

  // Qualified strobes and next occupancy; push+pop together leaves count unchanged.
  always_comb begin
    w_push      = i_push & ~r_full;
    w_pop       = i_pop & ~r_empty;
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign o_rd_data    = r_mem[r_rd_ptr];
  assign o_full       = r_full;
  assign o_empty      = r_empty;
  assign o_full_nxt_c = (w_count_nxt == CNT_W'(DEPTH));

endmodule

// File: rtl/energy_telemetry_tx.sv
// Energy telemetry transmitter: buffers 8-bit samples and sends each as a
// 4-byte UART 8N1 frame {A5, seq, sample, chk}, back-to-back while samples wait.
//   clk, rst     : clock, synchronous active-high reset
//   sample_in    : sample from the data collector
//   sample_valid : sample_in valid this cycle
//   sample_ready : buffer has room (registered)
//   tx           : serial line, idle high (registered)
//   busy         : frame on the line (registered)
//   frame_seq    : sequence number of frame in flight or last sent
module energy_telemetry_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic       sample_ready,
  output logic       tx,
  output logic       busy,
  output logic [7:0] frame_seq
);

  import energy_tx_pkg::*;

  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [1:0] BYTE_LAST = 2'(FRAME_BYTES - 1);

  tx_state_e   r_state;
  tx_state_e   w_state_nxt;
  logic [7:0]  r_baud;
  logic [7:0]  w_baud_nxt;
  logic [2:0]  r_bit_idx;
  logic [2:0]  w_bit_idx_nxt;
  logic [1:0]  r_byte_idx;
  logic [1:0]  w_byte_idx_nxt;
  logic [7:0]  r_seq;
  logic [7:0]  w_seq_nxt;
  frame_t      r_frame;
  frame_t      w_frame_nxt;
  logic        r_tx;
  logic        w_tx_nxt;
  logic        r_busy;
  logic        w_busy_nxt;
  logic        r_sample_ready;
  logic        w_push;
  logic        w_pop;
  logic        w_start_frame;
  logic        w_baud_end;
  logic [7:0]  w_cur_byte;
  logic [7:0]  w_fifo_dout;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic        w_fifo_full_nxt;

  assign w_push = sample_valid & r_sample_ready & ~w_fifo_full;

  telemetry_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_wr_data    (sample_in),
    .o_rd_data    (w_fifo_dout),
    .o_full       (w_fifo_full),
    .o_empty      (w_fifo_empty),
    .o_full_nxt_c (w_fifo_full_nxt)
  );

  // Next-state, counters and line level. tx/busy are registered from the
  // current state, so the line trails the FSM by one cycle uniformly.
  always_comb begin
    w_state_nxt    = r_state;
    w_baud_nxt     = r_baud;
    w_bit_idx_nxt  = r_bit_idx;
    w_byte_idx_nxt = r_byte_idx;
    w_frame_nxt    = r_frame;
    w_seq_nxt      = r_seq;
    w_pop          = 1'b0;
    w_start_frame  = 1'b0;
    w_tx_nxt       = 1'b1;
    w_busy_nxt     = (r_state != IDLE);
    w_baud_end     = (r_baud == BAUD_LAST);
    w_cur_byte     = frame_byte(r_frame, r_byte_idx);

    if (r_state != IDLE) begin
      w_baud_nxt = w_baud_end ? 8'd0 : r_baud + 8'd1;
    end

    case (r_state)
      IDLE: begin
        w_start_frame = ~w_fifo_empty;
      end
      START: begin
        w_tx_nxt = 1'b0;
        if (w_baud_end) begin
          w_state_nxt   = DATA;
          w_bit_idx_nxt = 3'd0;
        end
      end
      DATA: begin
        w_tx_nxt = w_cur_byte[r_bit_idx];
        if (w_baud_end) begin
          if (r_bit_idx == 3'd7) w_state_nxt = STOP;
          else                   w_bit_idx_nxt = r_bit_idx + 3'd1;
        end
      end
      STOP: begin
        w_tx_nxt = 1'b1;
        if (w_baud_end) begin
          if (r_byte_idx == BYTE_LAST) begin
            if (!w_fifo_empty) begin
              w_start_frame = 1'b1;
            end else begin
              w_state_nxt    = IDLE;
              w_bit_idx_nxt  = 3'd0;
              w_byte_idx_nxt = 2'd0;
            end
          end else begin
            w_byte_idx_nxt = r_byte_idx + 2'd1;
            w_state_nxt    = START;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Frame start: pop the head sample and claim the next sequence number.
    if (w_start_frame) begin
      w_pop              = 1'b1;
      w_state_nxt        = START;
      w_baud_nxt         = 8'd0;
      w_bit_idx_nxt      = 3'd0;
      w_byte_idx_nxt     = 2'd0;
      w_frame_nxt.seq    = r_seq;
      w_frame_nxt.sample = w_fifo_dout;
      w_seq_nxt          = r_seq + 8'd1;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_baud         <= 8'd0;
      r_bit_idx      <= 3'd0;
      r_byte_idx     <= 2'd0;
      r_seq          <= 8'd0;
      r_frame        <= '0;
      r_tx           <= 1'b1;
      r_busy         <= 1'b0;
      r_sample_ready <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_baud         <= w_baud_nxt;
      r_bit_idx      <= w_bit_idx_nxt;
      r_byte_idx     <= w_byte_idx_nxt;
      r_seq          <= w_seq_nxt;
      r_frame        <= w_frame_nxt;
      r_tx           <= w_tx_nxt;
      r_busy         <= w_busy_nxt;
      r_sample_ready <= ~w_fifo_full_nxt;
    end
  end

  assign sample_ready = r_sample_ready;
  assign tx           = r_tx;
  assign busy         = r_busy;
  assign frame_seq    = r_frame.seq;

endmodule
